// File: rtl/mux_rr_arbiter.sv
// Round-robin ownership controller for a shared 4:1 N-bit mux: grants one of
// four requesters, caps each grant at MAX_HOLD words and registers the word onto Y.
module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [3:0]   REQ,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  output logic [3:0]   GNT,
  output logic [1:0]   S,
  output logic [N-1:0] Y,
  output logic         VALID,
  output logic         BUSY
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e       state;
  logic [1:0]   last_owner;
  logic [7:0]   hold_cnt;
  logic [1:0]   arb_base;
  logic         win_valid;
  logic [1:0]   win_idx;
  logic [N-1:0] sel_data;

  // The scan starts just after the last owner; in IDLE that is the pointer,
  // which differs from S only right after reset (pointer = D, S = A).
  assign arb_base = (state == IDLE) ? last_owner : S;

  // NOTE: every signal driven in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = arb_base;
    // Walk the ring backwards so the candidate closest to arb_base+1 wins.
    for (int k = 4; k >= 1; k--) begin
      if (REQ[arb_base + 2'(k)]) begin
        win_valid = 1'b1;
        win_idx   = arb_base + 2'(k);
      end
    end
  end

  always_comb begin
    sel_data = A;
    unique case (S)
      2'd0: sel_data = A;
      2'd1: sel_data = B;
      2'd2: sel_data = C;
      2'd3: sel_data = D;
    endcase
  end

  assign BUSY = |GNT;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      GNT        <= 4'b0000;
      S          <= 2'd0;
      Y          <= '0;
      VALID      <= 1'b0;
      hold_cnt   <= 8'd0;
      last_owner <= 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          VALID <= 1'b0;
          if (win_valid) begin
            state      <= GRANT;
            GNT        <= 4'b0001 << win_idx;
            S          <= win_idx;
            last_owner <= win_idx;
            hold_cnt   <= 8'd0;
          end
        end
        GRANT: begin
          if (REQ[S]) begin
            Y     <= sel_data;
            VALID <= 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              // Hold expiry: hand over on the same edge, so no bubble.
              GNT        <= 4'b0001 << win_idx;
              S          <= win_idx;
              last_owner <= win_idx;
              hold_cnt   <= 8'd0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else begin
            VALID    <= 1'b0;
            hold_cnt <= 8'd0;
            if (win_valid) begin
              GNT        <= 4'b0001 << win_idx;
              S          <= win_idx;
              last_owner <= win_idx;
            end else begin
              state <= IDLE;
              GNT   <= 4'b0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance
// share stimulus; a reference model queues expected outputs per edge.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a, b, c, d;

  logic [3:0] gnt4, gnt1;
  logic [1:0] s4, s1;
  logic [3:0] y4, y1;
  logic       valid4, valid1, busy4, busy1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] s;
    logic [1:0] ptr;
    logic [3:0] y;
    logic       valid;
    int         cnt;
  } model_t;

  model_t m4, m1;
  model_t exp_q4[$];
  model_t exp_q1[$];

  mux_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .A(a), .B(b), .C(c), .D(d),
    .GNT(gnt4), .S(s4), .Y(y4), .VALID(valid4), .BUSY(busy4)
  );

  mux_rr_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .A(a), .B(b), .C(c), .D(d),
    .GNT(gnt1), .S(s1), .Y(y1), .VALID(valid1), .BUSY(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic model_t reset_model();
    model_t m;
    m.gnt = 4'b0000; m.s = 2'd0; m.ptr = 2'd3; m.y = 4'h0; m.valid = 1'b0; m.cnt = 0;
    return m;
  endfunction

  // First requester scanning cyclically from start+1 through start; -1 if none.
  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 1; k <= 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic model_t step(input model_t m, input int max_hold, input logic [3:0] r,
                                  input logic [3:0] da, db, dc, dd);
    model_t     n;
    logic [3:0] dat [4];
    int         win;
    n = m;
    dat[0] = da; dat[1] = db; dat[2] = dc; dat[3] = dd;
    if (m.gnt == 4'b0000) begin
      n.valid = 1'b0;
      win = pick(r, int'(m.ptr));
      if (win >= 0) begin
        n.gnt = 4'b0001 << win; n.s = 2'(win); n.ptr = 2'(win); n.cnt = 0;
      end
    end else if (r[m.s]) begin
      n.valid = 1'b1;
      n.y     = dat[m.s];
      if (m.cnt == max_hold - 1) begin
        win = pick(r, int'(m.s));
        n.gnt = 4'b0001 << win; n.s = 2'(win); n.ptr = 2'(win); n.cnt = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else begin
      n.valid = 1'b0;
      n.cnt   = 0;
      win = pick(r, int'(m.s));
      if (win >= 0) begin
        n.gnt = 4'b0001 << win; n.s = 2'(win); n.ptr = 2'(win);
      end else begin
        n.gnt = 4'b0000;
      end
    end
    return n;
  endfunction

  // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
  task automatic cycle(input logic [3:0] r);
    model_t e;
    req = r;
    m4 = step(m4, 4, r, a, b, c, d);
    m1 = step(m1, 1, r, a, b, c, d);
    exp_q4.push_back(m4);
    exp_q1.push_back(m1);
    @(posedge clk);
    #1;
    if (exp_q4.size() == 0 || exp_q1.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q4.pop_front();
      check("h4.gnt", gnt4, e.gnt);
      check("h4.s", s4, e.s);
      check("h4.y", y4, e.y);
      check("h4.valid", valid4, e.valid);
      check("h4.busy", busy4, |e.gnt);
      e = exp_q1.pop_front();
      check("h1.gnt", gnt1, e.gnt);
      check("h1.s", s1, e.s);
      check("h1.y", y1, e.y);
      check("h1.valid", valid1, e.valid);
      check("h1.busy", busy1, |e.gnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    m4 = reset_model();
    m1 = reset_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".gnt"}, gnt4, 4'b0000);
    check({tag, ".s"}, s4, 2'b00);
    check({tag, ".y"}, y4, 4'b0000);
    check({tag, ".valid"}, valid4, 1'b0);
    check({tag, ".busy"}, busy4, 1'b0);
  endtask

  initial begin
    logic [3:0] words [4];

    // Reset with random inputs applied.
    rst_n = 1'b0;
    req = 4'($urandom); a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
    m4 = reset_model();
    m1 = reset_model();
    #12;
    check_cleared("reset");
    check("reset.h1.gnt", gnt1, 4'b0000);
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    repeat (2) begin
      cycle(4'b0000);
      check("idle.gnt", gnt4, 4'b0000);
    end

    // Single requester C, re-granted at every hold expiry with no bubble.
    c = 4'b1010;
    cycle(4'b0100);
    check("single.gnt", gnt4, 4'b0100);
    check("single.s", s4, 2'b10);
    check("single.valid0", valid4, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0100);
      check("single.y", y4, 4'b1010);
      check("single.valid", valid4, 1'b1);
      check("single.hold_gnt", gnt4, 4'b0100);
    end
    cycle(4'b0000);

    // All four requesting: A,B,C,D each own four words.
    do_reset();
    a = 4'b0010; b = 4'b0110; c = 4'b1010; d = 4'b0011;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    cycle(4'b1111);
    check("all.first_gnt", gnt4, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      cycle(4'b1111);
      check("all.y", y4, words[i / 4]);
      check("all.valid", valid4, 1'b1);
    end
    check("all.wrap_gnt", gnt4, 4'b0001);

    // Owner A drops after two transfers: one bubble, then B.
    do_reset();
    cycle(4'b0011);
    check("drop.gnt_a", gnt4, 4'b0001);
    cycle(4'b0011);
    cycle(4'b0011);
    check("drop.y_a", y4, 4'b0010);
    cycle(4'b0010);
    check("drop.bubble_valid", valid4, 1'b0);
    check("drop.bubble_y", y4, 4'b0010);
    check("drop.gnt_b", gnt4, 4'b0010);
    check("drop.s_b", s4, 2'b01);
    cycle(4'b0010);
    check("drop.y_b", y4, 4'b0110);
    check("drop.valid_b", valid4, 1'b1);

    // Async reset while B owns the path with hold count 2.
    do_reset();
    repeat (7) cycle(4'b1111);
    check("async.pre_gnt", gnt4, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async");
    m4 = reset_model();
    m1 = reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111);
    check("async.after_gnt", gnt4, 4'b0001);
    check("async.after_valid", valid4, 1'b0);

    // MAX_HOLD=1 instance alternates B and D every word.
    do_reset();
    cycle(4'b1010);
    check("mh1.first_gnt", gnt1, 4'b0010);
    for (int k = 2; k <= 7; k++) begin
      cycle(4'b1010);
      check("mh1.gnt", gnt1, (k % 2 == 1) ? 4'b0010 : 4'b1000);
      check("mh1.y", y1, (k % 2 == 0) ? 4'b0110 : 4'b0011);
      check("mh1.valid", valid1, 1'b1);
    end

    // Random traffic, data refreshed occasionally.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      end
      cycle(4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 4:1 N-bit selection path between four requesters (A, B, C, D) using round-robin arbitration.
- Drives the select code S and a one-hot grant vector, and registers the selected word onto Y with a VALID strobe.
- Caps each grant at MAX_HOLD consecutive transfers so no requester starves the others.
- Sits in front of the N-bit 4:1 mux datapath as its sequencing and ownership controller.

Parameters:
- N, 4, data width of A/B/C/D/Y.
- MAX_HOLD, 4, max consecutive transfers per grant; legal range 1..255; counter width 8 bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D.
- A  input  N  requester 0 data.
- B  input  N  requester 1 data.
- C  input  N  requester 2 data.
- D  input  N  requester 3 data.
- GNT  output  4  registered one-hot grant; 0 when idle.
- S  output  2  registered select code of current owner (00=A, 01=B, 10=C, 11=D).
- Y  output  N  registered selected data.
- VALID  output  1  registered; Y holds a transferred word this cycle.
- BUSY  output  1  equals |GNT.

Behaviour:
- Reset: RST_N low asynchronously forces GNT=0000, S=00, Y=0, VALID=0, hold count=0, state IDLE.
  - The round-robin pointer resets to "last=D", so A has first priority after reset.
  - Reset asserted mid-grant aborts the grant immediately; no partial transfer is emitted.
- States: IDLE (GNT=0) and GRANT (GNT one-hot, S matches GNT).
- Arbitration function: choose the first requester with REQ set, scanning cyclically from S+1 (mod 4) through S itself.
  - In IDLE, the scan uses the pointer (last owner).
- IDLE:
  - REQ=0000: stay IDLE; S holds its last value; VALID=0.
  - Any REQ set: at the next edge load GNT/S with the winner, hold count=0, go to GRANT, VALID=0.
- GRANT, a transfer cycle is one where REQ[S]=1:
  - At the next edge Y<=selected input (A/B/C/D per S) and VALID<=1.
  - Data latency is one cycle from input to Y.
- GRANT, REQ[S]=1 and hold count<MAX_HOLD-1: count++, and the grant is unchanged.
- GRANT, REQ[S]=1 and hold count=MAX_HOLD-1 (hold expiry):
  - The transfer still occurs.
  - At the same edge, re-arbitrate from S+1. If the current owner is the only requester, it is re-granted.
  - Count resets to 0. There is no bubble, so VALID stays 1 across the handover.
- GRANT, REQ[S]=0 (owner dropped):
  - No transfer; VALID<=0 and Y holds its value.
  - At the same edge, re-arbitrate among the remaining REQ bits from S+1. If none are set, go to IDLE with GNT=0000.
  - This costs exactly one bubble cycle.
- Simultaneous requests: resolved only by the rotating scan; no fixed priority except immediately after reset.
- Y changes only on transfer cycles; a non-transfer cycle never updates it.
- MAX_HOLD=1: every transfer is a hold expiry, giving strict per-word rotation among active requesters.
- Requesters must hold their data stable while REQ is high.
- REQ of a non-owner may toggle freely without affecting the current grant.

Test Plan:
- Reset: RST_N=0 with random inputs -> GNT=0000, S=00, Y=0000, VALID=0, BUSY=0. Release RST_N with REQ=0000 -> outputs stay at reset values.
- Single requester, N=4, MAX_HOLD=4: REQ=0100, C=1010 -> GNT=0100 and S=10 one edge later. From the second edge, VALID=1 and Y=1010 continuously; at hold expiry C is re-granted with no bubble.
- All requesting: REQ=1111, A=0010, B=0110, C=1010, D=0011 -> grant order A,B,C,D,A. Y shows 0010 x4, 0110 x4, 1010 x4, 0011 x4 with VALID never dropping after the first word.
- Owner drop: REQ=0011, deassert REQ[0] after 2 transfers -> one cycle VALID=0 with Y=0010 held, then GNT=0010, S=01, and Y=0110 from the following edge.
- Async reset mid-grant: REQ=1111 in GRANT(B) with count=2, pulse RST_N low between edges -> outputs clear immediately without waiting for CLK. After release, A is granted first.
- MAX_HOLD=1 instance: REQ=1010 -> GNT alternates 0010, 1000, 0010, ... each cycle; Y alternates B, D with VALID=1 continuously.
